// File: rtl/mpu_regs_pkg.sv
// -----------------------------------------------------------------------------
// mpu_regs_pkg
// Shared definitions for the MPU-6050 register-interface model: register
// addresses, the PWR_MGMT_1 reset value and the I2C target FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package mpu_regs_pkg;

  // Sensor data block, big-endian, contiguous from ACCEL_XOUT_H to GYRO_ZOUT_L
  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] TEMP_OUT_H   = 8'h41;
  localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
  localparam logic [7:0] GYRO_ZOUT_L  = 8'h48;
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] WHO_AM_I     = 8'h75;

  // Device comes out of reset asleep
  localparam logic [7:0] PWR_MGMT_1_RST = 8'h40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Two-flop synchronizer followed by a glitch filter for one open-drain I2C
// line. A level change is accepted only after FILTER_LEN consecutive
// synchronized samples disagree with the current filtered level.
//
// Ports:
//   clk_50mhz  in  system clock
//   reset_n    in  asynchronous active-low reset
//   raw        in  raw pad level
//   level      out filtered level (resets to RESET_LEVEL, i.e. idle bus high)
//   rise       out one-cycle strobe, coincident with level going 0->1
//   fall       out one-cycle strobe, coincident with level going 1->0
// -----------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk_50mhz,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] diff_cnt;

  // diff_cnt counts how many samples in a row have disagreed with level;
  // the FILTER_LEN-th disagreeing sample commits the new level and strobes.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1  <= RESET_LEVEL;
      sync_q2  <= RESET_LEVEL;
      level    <= RESET_LEVEL;
      diff_cnt <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync_q2 == level) begin
        diff_cnt <= '0;
      end else if (diff_cnt == CW'(FILTER_LEN - 1)) begin
        level    <= sync_q2;
        rise     <= sync_q2;
        fall     <= ~sync_q2;
        diff_cnt <= '0;
      end else begin
        diff_cnt <= diff_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpu_i2c_target.sv
// -----------------------------------------------------------------------------
// mpu_i2c_target
// I2C target model of the MPU-6050 register interface. Serves a register map
// built from parallel sensor inputs (snapshotted at each read address phase)
// plus a writable PWR_MGMT_1. Open-drain: only ever pulls SDA low.
//
// Ports:
//   clk_50mhz          in  system clock
//   reset_n            in  asynchronous active-low reset
//   scl_in, sda_in     in  raw bus levels
//   sda_oe             out 1 = pull SDA low, 0 = release
//   ax, ay, az         in  signed accel sample
//   temp               in  signed temperature sample
//   gx, gy, gz         in  signed gyro sample
//   pwr_mgmt_1         out register 0x6B
//   sleep              out pwr_mgmt_1[6]
//   rd_done            out one-cycle pulse when the master NACKs a read byte
//   busy               out high between START and STOP
// -----------------------------------------------------------------------------
module mpu_i2c_target
  import mpu_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYCLES = 10
) (
  input  logic               clk_50mhz,
  input  logic               reset_n,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic               sda_oe,
  input  logic signed [15:0] ax,
  input  logic signed [15:0] ay,
  input  logic signed [15:0] az,
  input  logic signed [15:0] temp,
  input  logic signed [15:0] gx,
  input  logic signed [15:0] gy,
  input  logic signed [15:0] gz,
  output logic [7:0]         pwr_mgmt_1,
  output logic               sleep,
  output logic               rd_done,
  output logic               busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_LEVEL(1'b1)) u_scl_filter (
    .clk_50mhz (clk_50mhz),
    .reset_n   (reset_n),
    .raw       (scl_in),
    .level     (scl_level),
    .rise      (scl_rise),
    .fall      (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_LEVEL(1'b1)) u_sda_filter (
    .clk_50mhz (clk_50mhz),
    .reset_n   (reset_n),
    .raw       (sda_in),
    .level     (sda_level),
    .rise      (sda_rise),
    .fall      (sda_fall)
  );

  logic start_det;
  logic stop_det;

  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;
  assign sleep     = pwr_mgmt_1[6];

  i2c_state_t     state;
  logic [3:0]     bit_cnt;
  logic [7:0]     shift_reg;
  logic [7:0]     tx_shift;
  logic [7:0]     ptr;
  logic           rw;
  logic           sda_pending;
  logic           hold_active;
  logic [HW-1:0]  hold_cnt;
  logic [111:0]   shadow;
  logic [7:0]     rd_byte;

  // Read-side register map. The sensor block is one contiguous big-endian
  // run in the shadow, so the byte is picked by its offset from ACCEL_XOUT_H.
  always_comb begin
    logic [111:0] shifted;
    rd_byte = 8'h00;
    shifted = '0;
    if (ptr >= ACCEL_XOUT_H && ptr < TEMP_OUT_H ||
        ptr >= TEMP_OUT_H   && ptr < GYRO_XOUT_H ||
        ptr >= GYRO_XOUT_H  && ptr <= GYRO_ZOUT_L) begin
      shifted = shadow << {4'(ptr - ACCEL_XOUT_H), 3'b000};
      rd_byte = shifted[111:104];
    end else if (ptr == PWR_MGMT_1) begin
      rd_byte = pwr_mgmt_1;
    end else if (ptr == WHO_AM_I) begin
      rd_byte = {1'b0, DEV_ADDR};
    end
  end

  // Main protocol FSM. STOP then START take priority over any SCL edge.
  // Bits are sampled on SCL rise; on SCL fall the FSM decides the next SDA
  // value into sda_pending, which reaches sda_oe only HOLD_CYCLES later so
  // the data hold time after SCL low is respected. Releases caused by
  // START/STOP/IGNORE bypass the hold and take effect immediately.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      tx_shift    <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      sda_pending <= 1'b0;
      hold_active <= 1'b0;
      hold_cnt    <= '0;
      shadow      <= '0;
      sda_oe      <= 1'b0;
      pwr_mgmt_1  <= PWR_MGMT_1_RST;
      rd_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (stop_det) begin
        state       <= ST_IDLE;
        bit_cnt     <= '0;
        sda_oe      <= 1'b0;
        sda_pending <= 1'b0;
        hold_active <= 1'b0;
        busy        <= 1'b0;
      end else if (start_det) begin
        state       <= ST_ADDR;
        bit_cnt     <= '0;
        sda_oe      <= 1'b0;
        sda_pending <= 1'b0;
        hold_active <= 1'b0;
        busy        <= 1'b1;
      end else begin
        if (hold_active) begin
          if (hold_cnt == HW'(1)) begin
            sda_oe      <= sda_pending;
            hold_active <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        if (scl_rise) begin
          case (state)
            ST_ADDR, ST_PTR, ST_WR_DATA: begin
              if (bit_cnt < 4'd8) begin
                shift_reg <= {shift_reg[6:0], sda_level};
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
            ST_RD_ACK: begin
              if (sda_level) begin
                rd_done <= 1'b1;
                state   <= ST_IGNORE;
              end
            end
            default: ;
          endcase
        end else if (scl_fall) begin
          hold_active <= 1'b1;
          hold_cnt    <= HW'(HOLD_CYCLES);
          case (state)
            ST_ADDR: begin
              if (bit_cnt == 4'd8) begin
                if (shift_reg[7:1] == DEV_ADDR) begin
                  state       <= ST_ADDR_ACK;
                  rw          <= shift_reg[0];
                  sda_pending <= 1'b1;
                  if (shift_reg[0]) begin
                    shadow <= {ax, ay, az, temp, gx, gy, gz};
                  end
                end else begin
                  state       <= ST_IGNORE;
                  sda_pending <= 1'b0;
                  sda_oe      <= 1'b0;
                end
              end
            end
            ST_ADDR_ACK: begin
              bit_cnt <= '0;
              if (rw) begin
                state       <= ST_RD_BYTE;
                tx_shift    <= rd_byte;
                sda_pending <= ~rd_byte[7];
              end else begin
                state       <= ST_PTR;
                sda_pending <= 1'b0;
              end
            end
            ST_PTR: begin
              if (bit_cnt == 4'd8) begin
                ptr         <= shift_reg;
                state       <= ST_PTR_ACK;
                sda_pending <= 1'b1;
              end
            end
            ST_PTR_ACK: begin
              state       <= ST_WR_DATA;
              bit_cnt     <= '0;
              sda_pending <= 1'b0;
            end
            ST_WR_DATA: begin
              if (bit_cnt == 4'd8) begin
                if (ptr == PWR_MGMT_1) begin
                  pwr_mgmt_1 <= shift_reg;
                end
                state       <= ST_WR_ACK;
                sda_pending <= 1'b1;
              end
            end
            ST_WR_ACK: begin
              ptr         <= ptr + 8'd1;
              state       <= ST_WR_DATA;
              bit_cnt     <= '0;
              sda_pending <= 1'b0;
            end
            ST_RD_BYTE: begin
              if (bit_cnt == 4'd7) begin
                state       <= ST_RD_ACK;
                bit_cnt     <= '0;
                ptr         <= ptr + 8'd1;
                sda_pending <= 1'b0;
              end else begin
                bit_cnt     <= bit_cnt + 4'd1;
                tx_shift    <= {tx_shift[6:0], 1'b0};
                sda_pending <= ~tx_shift[6];
              end
            end
            ST_RD_ACK: begin
              // Still here on the fall means the master ACKed: next byte
              state       <= ST_RD_BYTE;
              bit_cnt     <= '0;
              tx_shift    <= rd_byte;
              sda_pending <= ~rd_byte[7];
            end
            ST_IGNORE: begin
              sda_pending <= 1'b0;
              sda_oe      <= 1'b0;
            end
            default: sda_pending <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule
